// File: rtl/decode_pipe_pkg.sv
// Shared types for the decode stage: operation enum, MIPS opcodes and the
// decoded-field record produced by the instruction decoder.
package decode_pipe_pkg;

    typedef enum logic [2:0] {
        OP_R    = 3'd0,
        OP_ADDI = 3'd1,
        OP_BEQ  = 3'd2,
        OP_LW   = 3'd3,
        OP_SW   = 3'd4,
        OP_J    = 3'd5,
        OP_ILL  = 3'd6
    } op_t;

    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2B;
    localparam logic [5:0] OPC_J    = 6'h02;

    // Register fields in the instruction word are always 5 bits wide.
    localparam int FIELD_AW = 5;
    // The jump-target field is carried at the core's standard PC width.
    localparam int JMP_W    = 8;

    typedef struct packed {
        op_t                 op;
        logic [FIELD_AW-1:0] rs_a;
        logic [FIELD_AW-1:0] rt_a;
        logic [FIELD_AW-1:0] rd_a;
        logic [15:0]         imm;
        logic [JMP_W-1:0]    pc_jmp;
    } dec_fields_t;

endpackage

// File: rtl/decode_pipe_if.sv
// Fetch-side, write-back and execute-side signals of the decode stage.
// The master drives fetch/write-back/flush and consumes the D/E outputs;
// the slave is the decode stage itself.
interface decode_pipe_if
    import decode_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int PC_W   = 8
);
    localparam int AW = $clog2(NREG);

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    op_t               out_op;
    logic [AW-1:0]     out_rs_a;
    logic [AW-1:0]     out_rt_a;
    logic [AW-1:0]     out_rd_a;
    logic [DATA_W-1:0] out_rs;
    logic [DATA_W-1:0] out_rt;
    logic [DATA_W-1:0] out_imm;
    logic [PC_W-1:0]   out_pc;
    logic [PC_W-1:0]   out_pc_jmp;

    modport master (
        output in_valid, in_instr, in_pc, wb_en, wb_addr, wb_data, flush, out_ready,
        input  in_ready, out_valid, out_op, out_rs_a, out_rt_a, out_rd_a,
               out_rs, out_rt, out_imm, out_pc, out_pc_jmp
    );

    modport slave (
        input  in_valid, in_instr, in_pc, wb_en, wb_addr, wb_data, flush, out_ready,
        output in_ready, out_valid, out_op, out_rs_a, out_rt_a, out_rd_a,
               out_rs, out_rt, out_imm, out_pc, out_pc_jmp
    );

endinterface

// File: rtl/decode_pipe_regfile_bypass.sv
// NREG x DATA_W register file with two read ports and one write port.
// Register 0 is hard-wired to zero; a read of the register being written in
// the same cycle returns the incoming write-back value.
module regfile_bypass #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data
);

    logic [DATA_W-1:0] regs [NREG];

    // Storage: cleared on reset, written on the clock edge unless targeting r0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read port A with write-through bypass; r0 always reads zero.
    always_comb begin
        ra_data = '0;
        if (ra_addr != '0) begin
            if (wr_en && wr_addr == ra_addr) ra_data = wr_data;
            else                             ra_data = regs[ra_addr];
        end
    end

    // Read port B with write-through bypass; r0 always reads zero.
    always_comb begin
        rb_data = '0;
        if (rb_addr != '0) begin
            if (wr_en && wr_addr == rb_addr) rb_data = wr_data;
            else                             rb_data = regs[rb_addr];
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// Instruction-decode stage: decodes the fetched MIPS word, reads operands
// from the register file, and holds the result in the D/E pipeline register.
// Stalls on a load-use hazard against the load currently held in D/E and
// keeps held operands current with write-backs while execute is stalled.
module decode_pipe
    import decode_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int PC_W   = 8
) (
    input  logic          clk,
    input  logic          reset,
    decode_pipe_if.slave  bus
);

    localparam int AW = $clog2(NREG);

    dec_fields_t       dec;
    logic [AW-1:0]     rs_a;
    logic [AW-1:0]     rt_a;
    logic [AW-1:0]     rd_a;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic              hazard;
    logic              accept;

    // Decode the incoming word; unknown opcodes become ILL with no registers.
    always_comb begin
        dec        = '0;
        dec.op     = OP_ILL;
        dec.imm    = bus.in_instr[15:0];
        dec.pc_jmp = JMP_W'(bus.in_instr[PC_W-1:0]);
        case (bus.in_instr[31:26])
            OPC_R: begin
                dec.op   = OP_R;
                dec.rs_a = bus.in_instr[25:21];
                dec.rt_a = bus.in_instr[20:16];
                dec.rd_a = bus.in_instr[15:11];
            end
            OPC_ADDI: begin
                dec.op   = OP_ADDI;
                dec.rs_a = bus.in_instr[25:21];
                dec.rd_a = bus.in_instr[20:16];
            end
            OPC_BEQ: begin
                dec.op   = OP_BEQ;
                dec.rs_a = bus.in_instr[25:21];
                dec.rt_a = bus.in_instr[20:16];
            end
            OPC_LW: begin
                dec.op   = OP_LW;
                dec.rs_a = bus.in_instr[25:21];
                dec.rd_a = bus.in_instr[20:16];
            end
            OPC_SW: begin
                dec.op   = OP_SW;
                dec.rs_a = bus.in_instr[25:21];
                dec.rt_a = bus.in_instr[20:16];
            end
            OPC_J: begin
                dec.op = OP_J;
            end
            default: begin
                dec.op = OP_ILL;
            end
        endcase
    end

    assign rs_a    = AW'(dec.rs_a);
    assign rt_a    = AW'(dec.rt_a);
    assign rd_a    = AW'(dec.rd_a);
    assign imm_ext = {{(DATA_W-16){dec.imm[15]}}, dec.imm};

    regfile_bypass #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (AW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.wb_en),
        .wr_addr (bus.wb_addr),
        .wr_data (bus.wb_data),
        .ra_addr (rs_a),
        .ra_data (rs_data),
        .rb_addr (rt_a),
        .rb_data (rt_data)
    );

    // A load in D/E whose destination feeds the incoming instruction must not
    // be followed directly; hold fetch until the load has moved on.
    assign hazard = bus.out_valid && (bus.out_op == OP_LW) && (bus.out_rd_a != '0) &&
                    (((rs_a != '0) && (rs_a == bus.out_rd_a)) ||
                     ((rt_a != '0) && (rt_a == bus.out_rd_a)));

    assign bus.in_ready = reset && !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // D/E register: flush beats load, load beats drain, otherwise hold and refresh operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.out_valid  <= 1'b0;
            bus.out_op     <= OP_R;
            bus.out_rs_a   <= '0;
            bus.out_rt_a   <= '0;
            bus.out_rd_a   <= '0;
            bus.out_rs     <= '0;
            bus.out_rt     <= '0;
            bus.out_imm    <= '0;
            bus.out_pc     <= '0;
            bus.out_pc_jmp <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid  <= 1'b1;
            bus.out_op     <= dec.op;
            bus.out_rs_a   <= rs_a;
            bus.out_rt_a   <= rt_a;
            bus.out_rd_a   <= rd_a;
            bus.out_rs     <= rs_data;
            bus.out_rt     <= rt_data;
            bus.out_imm    <= imm_ext;
            bus.out_pc     <= bus.in_pc;
            bus.out_pc_jmp <= PC_W'(dec.pc_jmp);
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end else begin
            if (bus.wb_en && bus.wb_addr != '0 && bus.wb_addr == bus.out_rs_a) bus.out_rs <= bus.wb_data;
            if (bus.wb_en && bus.wb_addr != '0 && bus.wb_addr == bus.out_rt_a) bus.out_rt <= bus.wb_data;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: a vector table of back-to-back instructions plus
// hand-written sequences for load-use stall, held-operand refresh, reset
// while stalled and flush. Expected D/E contents are queued when an
// instruction is offered and popped when it appears at the output.
module tb_decode_pipe;
    import decode_pipe_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  pc;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        op_t         eop;
        logic [4:0]  ers;
        logic [4:0]  ert;
        logic [4:0]  erd;
    } vec_t;

    typedef struct {
        op_t         op;
        logic [4:0]  rs_a;
        logic [4:0]  rt_a;
        logic [4:0]  rd_a;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [7:0]  pc;
        logic [7:0]  pc_jmp;
    } exp_t;

    logic        clk;
    logic        reset;
    int          passed;
    int          total;
    exp_t        sb[$];
    exp_t        held;
    logic        mvalid;
    logic [31:0] mregs [32];
    vec_t        vecs [9];

    decode_pipe_if #(.DATA_W(32), .NREG(32), .PC_W(8)) bus ();

    decode_pipe #(.DATA_W(32), .NREG(32), .PC_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        else             passed++;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic wen,
                                               input logic [4:0] waddr, input logic [31:0] wdata);
        if (a == 5'd0)               return 32'h0;
        if (wen && waddr == a)       return wdata;
        return mregs[a];
    endfunction

    task automatic check_output(input logic pushed);
        check("out_valid", 32'(bus.out_valid), 32'(mvalid));
        if (pushed) begin
            if (sb.size() == 0) check("scoreboard_empty", 32'(sb.size()), 32'd1);
            else                held = sb.pop_front();
        end
        if (mvalid) begin
            check("out_op",     32'(bus.out_op),     32'(held.op));
            check("out_rs_a",   32'(bus.out_rs_a),   32'(held.rs_a));
            check("out_rt_a",   32'(bus.out_rt_a),   32'(held.rt_a));
            check("out_rd_a",   32'(bus.out_rd_a),   32'(held.rd_a));
            check("out_rs",     bus.out_rs,          held.rs);
            check("out_rt",     bus.out_rt,          held.rt);
            check("out_imm",    bus.out_imm,         held.imm);
            check("out_pc",     32'(bus.out_pc),     32'(held.pc));
            check("out_pc_jmp", 32'(bus.out_pc_jmp), 32'(held.pc_jmp));
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [31:0] instr, input logic [7:0] pc,
                                  input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                                  input logic fl, input logic ordy, input logic exp_ready,
                                  input op_t eop, input logic [4:0] ers, input logic [4:0] ert,
                                  input logic [4:0] erd);
        exp_t e;
        logic pushed;
        @(negedge clk);
        bus.in_valid  = valid;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.wb_en     = wen;
        bus.wb_addr   = waddr;
        bus.wb_data   = wdata;
        bus.flush     = fl;
        bus.out_ready = ordy;
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        pushed = 1'b0;
        if (valid && exp_ready) begin
            e.op     = eop;
            e.rs_a   = ers;
            e.rt_a   = ert;
            e.rd_a   = erd;
            e.rs     = model_read(ers, wen, waddr, wdata);
            e.rt     = model_read(ert, wen, waddr, wdata);
            e.imm    = {{16{instr[15]}}, instr[15:0]};
            e.pc     = pc;
            e.pc_jmp = instr[7:0];
            sb.push_back(e);
            pushed = 1'b1;
        end
        @(posedge clk);
        if (wen && waddr != 5'd0) mregs[waddr] = wdata;
        if (fl)                   mvalid = 1'b0;
        else if (pushed)          mvalid = 1'b1;
        else if (mvalid && ordy)  mvalid = 1'b0;
        else if (mvalid && wen && waddr != 5'd0) begin
            if (waddr == held.rs_a) held.rs = wdata;
            if (waddr == held.rt_a) held.rt = wdata;
        end
        #1;
        check_output(pushed);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.wb_en     = 1'b0;
        bus.out_ready = 1'b1;
        reset         = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        sb.delete();
        mvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_rs",  bus.out_rs,        32'h0);
        check("rst_out_imm", bus.out_imm,       32'h0);
        check("rst_out_pc",  32'(bus.out_pc),   32'h0);
        check("rst_out_op",  32'(bus.out_op),   32'(OP_R));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        reset         = 1'b0;
        mvalid        = 1'b0;
        held          = '{OP_R, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 8'h0, 8'h0};
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.in_pc     = 8'h0;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = 5'd0;
        bus.wb_data   = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        vecs[0] = '{32'h20010005, 8'h10, 1'b0, 5'd0, 32'h0,        OP_ADDI, 5'd0, 5'd0, 5'd1};
        vecs[1] = '{32'h00632020, 8'h11, 1'b1, 5'd3, 32'h0000DEAD, OP_R,    5'd3, 5'd3, 5'd4};
        vecs[2] = '{32'h1064FFFC, 8'h12, 1'b1, 5'd4, 32'h00001234, OP_BEQ,  5'd3, 5'd4, 5'd0};
        vecs[3] = '{32'hAC820008, 8'h13, 1'b1, 5'd0, 32'h00000999, OP_SW,   5'd4, 5'd2, 5'd0};
        vecs[4] = '{32'h080ABCDE, 8'h14, 1'b0, 5'd0, 32'h0,        OP_J,    5'd0, 5'd0, 5'd0};
        vecs[5] = '{32'hFC421234, 8'h15, 1'b0, 5'd0, 32'h0,        OP_ILL,  5'd0, 5'd0, 5'd0};
        vecs[6] = '{32'h8C260004, 8'h16, 1'b1, 5'd1, 32'h00000077, OP_LW,   5'd1, 5'd0, 5'd6};
        vecs[7] = '{32'h20A2FFFF, 8'h17, 1'b1, 5'd7, 32'h0000AAAA, OP_ADDI, 5'd5, 5'd0, 5'd2};
        vecs[8] = '{32'h00004820, 8'h18, 1'b1, 5'd0, 32'h00005A5A, OP_R,    5'd0, 5'd0, 5'd9};

        do_reset();

        // Back-to-back decode of every instruction class with execute always ready.
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].wen, vecs[i].waddr,
                           vecs[i].wdata, 1'b0, 1'b1, 1'b1,
                           vecs[i].eop, vecs[i].ers, vecs[i].ert, vecs[i].erd);
        end
        apply_stimulus(1'b0, 32'h0, 8'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, OP_R, 5'd0, 5'd0, 5'd0);

        // Load-use: LW r2 then R r5=r2+r0 stalls one cycle behind a bubble.
        apply_stimulus(1'b1, 32'h8C020000, 8'h20, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, OP_LW, 5'd0, 5'd0, 5'd2);
        apply_stimulus(1'b1, 32'h00402820, 8'h21, 1'b1, 5'd2, 32'h00003333, 1'b0, 1'b1, 1'b0, OP_R,  5'd2, 5'd0, 5'd5);
        apply_stimulus(1'b1, 32'h00402820, 8'h21, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, OP_R,  5'd2, 5'd0, 5'd5);
        apply_stimulus(1'b0, 32'h0,        8'h0,  1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, OP_R,  5'd0, 5'd0, 5'd0);

        // Stalled output: held R r8=r7+r1 picks up write-backs to r7 and r1.
        apply_stimulus(1'b1, 32'h00E14020, 8'h30, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, OP_R,    5'd7, 5'd1, 5'd8);
        apply_stimulus(1'b1, 32'h20010005, 8'h31, 1'b1, 5'd7, 32'h00000055, 1'b0, 1'b0, 1'b0, OP_ADDI, 5'd0, 5'd0, 5'd1);
        apply_stimulus(1'b0, 32'h0,        8'h0,  1'b1, 5'd1, 32'h00000066, 1'b0, 1'b0, 1'b0, OP_R,    5'd0, 5'd0, 5'd0);

        // Reset while stalled, then the same instruction is fetched again.
        do_reset();
        apply_stimulus(1'b1, 32'h00E14020, 8'h30, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, OP_R, 5'd7, 5'd1, 5'd8);

        // Flush squashes the held instruction and the one on offer.
        apply_stimulus(1'b1, 32'h20010005, 8'h40, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, OP_ADDI, 5'd0, 5'd0, 5'd1);
        apply_stimulus(1'b0, 32'h0,        8'h0,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, OP_R,    5'd0, 5'd0, 5'd0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
